exp_scheduler: RTL and testbench
================================

# exp_scheduler

Round-robin scheduler that shares one fast-exponentiation core (16-bit base, 8-bit exponent, result mod 2^16) between NREQ requesters. It accepts one request at a time and launches the core with a start pulse. It waits for the core's ready to rise again, then returns the result to the requester that issued it. It sits between the requesting blocks and the single exponentiation core, and is that core's only driver.

## Interface
- NREQ, 4: number of requesters, 2..8.
- clk  in  1: clock, all state updates on rising edge.
- nrst  in  1: asynchronous active-low reset.
- req  in  NREQ: request bit per requester.
- req_x  in  16*NREQ: base per requester; requester i uses bits [16i+15:16i].
- req_n  in  8*NREQ: exponent per requester; requester i uses bits [8i+7:8i].
- gnt  out  NREQ: one-hot, one-cycle pulse; the request is accepted.
- rsp_valid  out  NREQ: one-hot, one-cycle pulse; rsp_data belongs to this requester.
- rsp_data  out  16: result x^n mod 2^16; meaningful only while rsp_valid is nonzero.
- busy  out  1: high from the accept edge until the rsp_valid edge.
- core_start  out  1: start pulse to the core.
- core_x  out  16: base to the core.
- core_n  out  8: exponent to the core.
- core_ready  in  1: core idle/done flag.
- core_out  in  16: core result.

## Operation
- All outputs are registered.
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, busy=0, core_start=0, core_x=0, core_n=0. On reset, state=IDLE and the round-robin pointer ptr=0.
- The core shares clk/nrst with this block.
- States:
  - IDLE: if core_ready=1 and any req bit is set, choose the first set bit at or after ptr, wrapping modulo NREQ. Call its index k. At the clock edge:
    - latch idx=k;
    - drive core_x=req_x[k] and core_n=req_n[k];
    - assert core_start=1, gnt[k]=1 and busy=1;
    - set ptr=(k+1) mod NREQ;
    - go to LAUNCH.
  - IDLE: if core_ready=0, grant nothing and stay in IDLE.
  - LAUNCH: one cycle. core_ready is ignored in this cycle. At the edge, clear core_start and gnt, then go to WAIT.
  - WAIT: at the first edge with core_ready=1:
    - rsp_data<=core_out;
    - rsp_valid[idx]<=1;
    - busy<=0;
    - go to IDLE.
- rsp_valid clears on the next edge.
- Requester contract:
  - Hold req, req_x and req_n stable until gnt is seen.
  - Deassert req no later than the cycle after gnt.
  - Any req seen in IDLE is treated as a new request.
- A requester may drop req before it is granted, with no side effects.
- Only one request is outstanding system-wide. No queueing.
- core_x and core_n hold their value after launch; they are not cleared.
- Arithmetic is done entirely in the core. The scheduler does not check the result. Wrap-around mod 2^16 is expected behaviour.

## Timing
- Request seen in IDLE in cycle 0 gives:
  - gnt and core_start high in cycle 1;
  - core_ready low from cycle 2.
- rsp_valid goes high one cycle after core_ready rises.
- The core takes S steps plus one done cycle. S = number of halvings plus number of decrements.
- Total latency from req to rsp_valid is 4+S cycles; n=0 gives 4.
- A rsp_valid cycle is also an IDLE cycle, so the next grant can come on that edge. Back-to-back requests therefore have period 4+S.
- Simultaneous requests: strictly round-robin. Each active requester is served within NREQ grants.
- A req that arrives in the same cycle as rsp_valid competes normally, starting from the updated ptr.
- Reset mid-operation (any state) takes effect immediately:
  - all outputs return to their reset values and the state goes to IDLE;
  - the in-flight request is dropped and gets no rsp_valid.

## Test plan
- Single request: req[0]=1, x=3, n=5 -> gnt[0] in cycle 1, rsp_valid[0] in cycle 8, rsp_data=243; busy high in cycles 1-7.
- Zero exponent: req[2]=1, x=7, n=0 -> rsp_valid[2] in cycle 4, rsp_data=1.
- Wrap-around: x=2, n=16 -> rsp_data=0. x=3, n=10 -> rsp_data=59049.
- Contention: req=4'b1111 held continuously, each requester re-raising req after its own rsp, starting from ptr=0 -> gnt order 0,1,2,3,0. Each rsp_valid is one-hot and matches the preceding gnt.
- Core not ready: force core_ready=0 in IDLE with req[1]=1 -> no gnt until core_ready=1, then gnt[1] on the next edge.
- Reset in WAIT: pull nrst low during the cycle-4 busy period of the x=3, n=5 request -> all outputs 0 immediately, no rsp_valid afterwards. A new req[3] after reset is served with ptr=0 (gnt[3]).

Source files
------------

// File: rtl/exp_scheduler.sv
// exp_scheduler: round-robin arbiter in front of a single fast-exponentiation core.
// One request is outstanding at a time. The winner's operands go to the core with a
// one-cycle start pulse. The core result goes back to that requester once the core
// raises ready again.
//
// Ports:
//   clk_i, nrst_i        clock, asynchronous active-low reset (shared with the core)
//   req_i                request bit per requester
//   req_x_i, req_n_i     packed 16-bit base / 8-bit exponent per requester
//   gnt_o                one-hot, one-cycle pulse when a request is accepted
//   rsp_valid_o          one-hot, one-cycle pulse marking the owner of rsp_data_o
//   rsp_data_o           core result (x^n mod 2^16)
//   busy_o               high from the accept edge until the response edge
//   core_start_o         start pulse to the core
//   core_x_o, core_n_o   operands to the core; they hold after launch
//   core_ready_i         core idle/done flag
//   core_out_i           core result
module exp_scheduler #(
    parameter int unsigned NREQ = 4
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [16*NREQ-1:0]   req_x_i,
    input  logic [8*NREQ-1:0]    req_n_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [15:0]          rsp_data_o,
    output logic                 busy_o,
    output logic                 core_start_o,
    output logic [15:0]          core_x_o,
    output logic [7:0]           core_n_o,
    input  logic                 core_ready_i,
    input  logic [15:0]          core_out_i
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   idx_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic              busy_q;
    logic              core_start_q;
    logic [15:0]       core_x_q;
    logic [7:0]        core_n_q;

    logic [15:0]       x_arr [NREQ];
    logic [7:0]        n_arr [NREQ];

    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   ptr_next;
    logic [IdxW:0]     sum;
    logic [IdxW-1:0]   cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign x_arr[g] = req_x_i[16*g +: 16];
        assign n_arr[g] = req_n_i[8*g +: 8];
    end

    // First set request at or after ptr_q, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(NREQ)) begin
                sum = sum - (IdxW+1)'(NREQ);
            end
            cand = sum[IdxW-1:0];
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign ptr_next = (pick_idx == IdxW'(NREQ - 1)) ? '0 : pick_idx + IdxW'(1);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            idx_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            core_n_q     <= '0;
        end else begin
            // Both pulses last exactly one cycle.
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (core_ready_i && pick_found) begin
                        idx_q        <= pick_idx;
                        core_x_q     <= x_arr[pick_idx];
                        core_n_q     <= n_arr[pick_idx];
                        core_start_q <= 1'b1;
                        gnt_q        <= NREQ'(1) << pick_idx;
                        busy_q       <= 1'b1;
                        ptr_q        <= ptr_next;
                        state_q      <= StLaunch;
                    end
                end
                // The core's ready still reflects its pre-start state here, so it is ignored.
                StLaunch: begin
                    core_start_q <= 1'b0;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (core_ready_i) begin
                        rsp_data_q  <= core_out_i;
                        rsp_valid_q <= NREQ'(1) << idx_q;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign busy_o       = busy_q;
    assign core_start_o = core_start_q;
    assign core_x_o     = core_x_q;
    assign core_n_o     = core_n_q;

endmodule

// File: tb/tb_exp_scheduler.sv
module tb_exp_scheduler;

    localparam int NREQ = 4;

    logic              clk;
    logic              nrst;
    logic [NREQ-1:0]   req;
    logic [16*NREQ-1:0] req_x;
    logic [8*NREQ-1:0] req_n;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_data;
    logic              busy;
    logic              core_start;
    logic [15:0]       core_x;
    logic [7:0]        core_n;
    logic              core_ready;
    logic [15:0]       core_out;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    // Behavioural core: ready drops after start, stays low for S+1 cycles.
    logic        core_rdy_q;
    logic [15:0] core_out_q;
    logic [15:0] core_pend_q;
    int          core_cnt_q;
    logic        hold_off;

    exp_scheduler #(.NREQ(NREQ)) dut (
        .clk_i        (clk),
        .nrst_i       (nrst),
        .req_i        (req),
        .req_x_i      (req_x),
        .req_n_i      (req_n),
        .gnt_o        (gnt),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .core_start_o (core_start),
        .core_x_o     (core_x),
        .core_n_o     (core_n),
        .core_ready_i (core_ready),
        .core_out_i   (core_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int steps(int n);
        int s = 0;
        while (n > 0) begin
            if (n % 2 == 1) n = n - 1;
            else n = n / 2;
            s++;
        end
        return s;
    endfunction

    function automatic logic [15:0] pow16(logic [15:0] x, int n);
        int unsigned r = 1;
        for (int i = 0; i < n; i++) r = (r * x) & 32'hFFFF;
        return r[15:0];
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            core_rdy_q  <= 1'b1;
            core_cnt_q  <= 0;
            core_out_q  <= 16'h0;
            core_pend_q <= 16'h0;
        end else if (core_start) begin
            core_rdy_q  <= 1'b0;
            core_cnt_q  <= steps(int'(core_n));
            core_pend_q <= pow16(core_x, int'(core_n));
            core_out_q  <= 16'hDEAD;
        end else if (!core_rdy_q) begin
            if (core_cnt_q == 0) begin
                core_rdy_q <= 1'b1;
                core_out_q <= core_pend_q;
            end else begin
                core_cnt_q <= core_cnt_q - 1;
            end
        end
    end

    assign core_ready = core_rdy_q & ~hold_off;
    assign core_out   = core_out_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int k, logic [15:0] x, logic [7:0] n);
        req_x[16*k +: 16] = x;
        req_n[8*k +: 8]   = n;
    endtask

    // Steps until a response appears; cyc is the cycle index counted from the grant cycle (1).
    task automatic wait_rsp(output int cyc, output bit to);
        cyc = 1;
        while (rsp_valid === '0 && cyc < 200) begin
            step();
            cyc++;
        end
        to = (rsp_valid === '0);
    endtask

    task automatic test_reset();
        nrst = 1'b0; req = '0; req_x = '0; req_n = '0; hold_off = 1'b0;
        #3;
        n_checks++;
        if ({gnt, rsp_valid, busy, core_start} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b rsp_valid=%b busy=%b start=%b want all 0",
                     gnt, rsp_valid, busy, core_start);
        end
        n_checks++;
        if ({rsp_data, core_x, core_n} !== 40'b0) begin
            n_fail++;
            $display("FAIL reset_data: got rsp_data=%h core_x=%h core_n=%h want 0",
                     rsp_data, core_x, core_n);
        end
        step();
        nrst = 1'b1;
        m_ptr = 0;
        step();
    endtask

    task automatic test_single();
        bit busy_ok = 1;
        req[0] = 1'b1; set_op(0, 16'd3, 8'd5);
        step();
        n_checks++;
        if (gnt !== 4'b0001 || core_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gnt: got gnt=%b start=%b busy=%b want 0001 1 1",
                     gnt, core_start, busy);
        end
        n_checks++;
        if (core_x !== 16'd3 || core_n !== 8'd5) begin
            n_fail++;
            $display("FAIL single_ops: got x=%0d n=%0d want 3 5", core_x, core_n);
        end
        req = '0;
        m_ptr = 1;
        for (int c = 2; c <= 7; c++) begin
            step();
            if (busy !== 1'b1 || rsp_valid !== '0 || gnt !== '0) busy_ok = 0;
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL single_busy: busy/pulses wrong in cycles 2-7 got 0 want 1");
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'd243 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got rsp_valid=%b data=%0d busy=%b want 0001 243 0",
                     rsp_valid, rsp_data, busy);
        end
        step();
        n_checks++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_rsp_clear: got rsp_valid=%b want 0000", rsp_valid);
        end
    endtask

    task automatic test_zero_exp();
        int cyc; bit to;
        req[2] = 1'b1; set_op(2, 16'd7, 8'd0);
        step();
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL zero_gnt: got %b want 0100", gnt);
        end
        req = '0;
        m_ptr = 3;
        wait_rsp(cyc, to);
        n_checks++;
        if (to || cyc != 4 || rsp_valid !== 4'b0100 || rsp_data !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_rsp: got cycle=%0d rsp_valid=%b data=%0d want 4 0100 1",
                     cyc, rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [15:0] xs [2] = '{16'd2, 16'd3};
        logic [7:0]  ns [2] = '{8'd16, 8'd10};
        logic [15:0] ex [2] = '{16'd0, 16'd59049};
        int cyc; bit to;
        for (int t = 0; t < 2; t++) begin
            req[3] = 1'b1; set_op(3, xs[t], ns[t]);
            step();
            n_checks++;
            if (gnt !== 4'b1000) begin
                n_fail++;
                $display("FAIL wrap_gnt%0d: got %b want 1000", t, gnt);
            end
            req = '0;
            m_ptr = 0;
            wait_rsp(cyc, to);
            n_checks++;
            if (to || cyc != 4 + steps(int'(ns[t])) || rsp_valid !== 4'b1000
                || rsp_data !== ex[t]) begin
                n_fail++;
                $display("FAIL wrap_rsp%0d: got cycle=%0d rsp_valid=%b data=%0d want %0d 1000 %0d",
                         t, cyc, rsp_valid, rsp_data, 4 + steps(int'(ns[t])), ex[t]);
            end
            step();
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [15:0] xs [NREQ];
        logic [7:0]  ns [NREQ];
        int k, cyc; bit to;
        for (int i = 0; i < NREQ; i++) begin
            xs[i] = 16'($urandom);
            ns[i] = 8'($urandom_range(0, 20));
            set_op(i, xs[i], ns[i]);
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            k = rr_pick(req, m_ptr);
            step();
            n_checks++;
            if (gnt !== (4'b0001 << order[g]) || gnt !== (4'b0001 << k)) begin
                n_fail++;
                $display("FAIL contention_gnt%0d: got %b want %b", g, gnt, 4'b0001 << order[g]);
            end
            m_ptr = (k + 1) % NREQ;
            req[k] = 1'b0;
            wait_rsp(cyc, to);
            n_checks++;
            if (to || cyc != 4 + steps(int'(ns[k])) || rsp_valid !== (4'b0001 << k)
                || rsp_data !== pow16(xs[k], int'(ns[k]))) begin
                n_fail++;
                $display("FAIL contention_rsp%0d: got cycle=%0d rsp_valid=%b data=%h want %0d %b %h",
                         g, cyc, rsp_valid, rsp_data, 4 + steps(int'(ns[k])), 4'b0001 << k,
                         pow16(xs[k], int'(ns[k])));
            end
            if (g < 4) req[k] = 1'b1;
        end
        req = '0;
        step();
    endtask

    task automatic test_core_not_ready();
        bit quiet = 1;
        int cyc; bit to;
        logic [15:0] x = 16'($urandom);
        logic [7:0]  n = 8'($urandom_range(0, 30));
        hold_off = 1'b1;
        req[1] = 1'b1; set_op(1, x, n);
        for (int c = 0; c < 4; c++) begin
            step();
            if (gnt !== '0 || busy !== 1'b0 || core_start !== 1'b0) quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL notready_hold: got a grant while core_ready=0 want none");
        end
        hold_off = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL notready_gnt: got %b want 0010", gnt);
        end
        req = '0;
        m_ptr = 2;
        wait_rsp(cyc, to);
        n_checks++;
        if (to || rsp_valid !== 4'b0010 || rsp_data !== pow16(x, int'(n))) begin
            n_fail++;
            $display("FAIL notready_rsp: got rsp_valid=%b data=%h want 0010 %h",
                     rsp_valid, rsp_data, pow16(x, int'(n)));
        end
        step();
    endtask

    task automatic test_random();
        logic [15:0] xs [NREQ];
        logic [7:0]  ns [NREQ];
        logic [NREQ-1:0] v;
        int k, cyc; bit to;
        for (int t = 0; t < 16; t++) begin
            v = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                xs[i] = 16'($urandom);
                ns[i] = 8'($urandom_range(0, 60));
                set_op(i, xs[i], ns[i]);
            end
            k = rr_pick(v, m_ptr);
            req = v;
            step();
            n_checks++;
            if (gnt !== (4'b0001 << k) || core_x !== xs[k] || core_n !== ns[k]) begin
                n_fail++;
                $display("FAIL random_gnt%0d: got gnt=%b x=%h n=%0d want %b %h %0d",
                         t, gnt, core_x, core_n, 4'b0001 << k, xs[k], ns[k]);
            end
            m_ptr = (k + 1) % NREQ;
            req = '0;
            wait_rsp(cyc, to);
            n_checks++;
            if (to || cyc != 4 + steps(int'(ns[k])) || rsp_valid !== (4'b0001 << k)
                || rsp_data !== pow16(xs[k], int'(ns[k]))) begin
                n_fail++;
                $display("FAIL random_rsp%0d: got cycle=%0d rsp_valid=%b data=%h want %0d %b %h",
                         t, cyc, rsp_valid, rsp_data, 4 + steps(int'(ns[k])), 4'b0001 << k,
                         pow16(xs[k], int'(ns[k])));
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_reset_in_wait();
        bit silent = 1;
        int cyc; bit to;
        req[1] = 1'b1; set_op(1, 16'd3, 8'd5);
        step();
        req = '0;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_busy: got busy=%b in cycle 4 want 1", busy);
        end
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({gnt, rsp_valid, busy, core_start} !== 10'b0
            || {rsp_data, core_x, core_n} !== 40'b0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: got gnt=%b rv=%b busy=%b st=%b d=%h x=%h n=%h want 0",
                     gnt, rsp_valid, busy, core_start, rsp_data, core_x, core_n);
        end
        step();
        nrst = 1'b1;
        m_ptr = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rsp_valid !== '0 || busy !== 1'b0) silent = 0;
        end
        n_checks++;
        if (!silent) begin
            n_fail++;
            $display("FAIL rstwait_dropped: got activity after reset want none");
        end
        req[3] = 1'b1; set_op(3, 16'd5, 8'd3);
        step();
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstwait_regnt: got %b want 1000", gnt);
        end
        req = '0;
        m_ptr = 0;
        wait_rsp(cyc, to);
        n_checks++;
        if (to || rsp_valid !== 4'b1000 || rsp_data !== 16'd125) begin
            n_fail++;
            $display("FAIL rstwait_rersp: got rsp_valid=%b data=%0d want 1000 125",
                     rsp_valid, rsp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_exp();
        test_wrap();
        test_contention();
        test_core_not_ready();
        test_random();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
